regdisp_native_forward: RTL

REGDISP_NATIVE_FORWARD -- requirements
Module: regdisp_native_forward

---
 rtl/regdisp_native_forward.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/regdisp_native_forward.sv
// Register-access dispatcher: forwards one upstream request to the downstream port picked by
// two address bits, waits for that port's ack (with timeout) and returns a single upstream ack.
module regdisp_native_forward #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int FORWARD_NUM = 3,
    parameter int SEL_LSB     = 12,
    parameter int TIMEOUT     = 255
) (
    input  logic                              fsm_clk,
    input  logic                              fsm_rstn,
    input  logic                              soft_rst,
    input  logic                              req_vld,
    input  logic                              wr_en,
    input  logic                              rd_en,
    input  logic [ADDR_WIDTH-1:0]             addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic                              ack_vld,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic [FORWARD_NUM-1:0]            fwd_req_vld,
    output logic                              fwd_wr_en,
    output logic                              fwd_rd_en,
    output logic [ADDR_WIDTH-1:0]             fwd_addr,
    output logic [DATA_WIDTH-1:0]             fwd_wr_data,
    input  logic [FORWARD_NUM-1:0]            fwd_ack_vld,
    input  logic [FORWARD_NUM*DATA_WIDTH-1:0] fwd_rd_data,
    output logic                              err_o
);

    typedef enum logic [1:0] {IDLE, FWD, WAIT, RESP} state_e;

    localparam logic [2:0]            PORT_CNT     = 3'(FORWARD_NUM);
    localparam logic [7:0]            TIMEOUT_CNT  = 8'(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;

    logic [1:0]            req_idx;
    logic                  req_ok;
    logic                  sel_ack;
    logic [DATA_WIDTH-1:0] sel_rdata;

    assign req_idx = addr[SEL_LSB+1:SEL_LSB];
    // Ambiguous access types (neither or both enables) are rejected like an unmapped port.
    assign req_ok  = (wr_en ^ rd_en) && ({1'b0, req_idx} < PORT_CNT);

    always_comb begin : sel_mux
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < FORWARD_NUM; k++) begin
            if (idx_q == k[1:0]) begin
                sel_ack   = fwd_ack_vld[k];
                sel_rdata = fwd_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // NOTE: every _d takes its _q value before any branch, so no path leaves a latch behind.
    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        rd_d    = rd_q;

        if (soft_rst) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_vld) begin
                        err_d   = !req_ok;
                        state_d = FWD;
                        if (req_ok) begin
                            idx_d   = req_idx;
                            addr_d  = addr;
                            wdata_d = wr_data;
                            wr_d    = wr_en;
                            rd_d    = rd_en;
                        end
                    end
                end
                // A rejected request spends this cycle as a bubble (no downstream pulse) so its
                // ack lands two cycles after the request.
                FWD: begin
                    cnt_d = '0;
                    if (err_q) begin
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (sel_ack) begin
                        rdata_d = rd_q ? sel_rdata : '0;
                        state_d = RESP;
                    end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
                        rdata_d = TIMEOUT_DATA;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
        if (!fsm_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin : fwd_pulse
        fwd_req_vld = '0;
        for (int k = 0; k < FORWARD_NUM; k++) begin
            fwd_req_vld[k] = (state_q == FWD) && !err_q && (idx_q == k[1:0]);
        end
    end

    assign fwd_addr    = addr_q;
    assign fwd_wr_data = wdata_q;
    assign fwd_wr_en   = wr_q;
    assign fwd_rd_en   = rd_q;
    assign ack_vld     = (state_q == RESP);
    assign rd_data     = rdata_q;
    // A request arriving while busy is flagged combinationally in the cycle it is dropped.
    assign err_o       = ((state_q == RESP) && err_q) || (req_vld && (state_q != IDLE));

endmodule
